// File: rtl/tx_lane_pkg.sv
// Shared constants and helpers for the transmit-path lane FIFO.
package tx_lane_pkg;

    localparam int LANE_W      = 9;
    localparam int TX_LANES_64 = 8;
    localparam int TX_LANES_32 = 4;

    // Ceiling log2 usable in parameter expressions; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/tx_lane_ram.sv
// Simple dual-port RAM: synchronous write, registered read, single clock.
module tx_lane_ram
    import tx_lane_pkg::*;
#(
    parameter int WIDTH = TX_LANES_64 * LANE_W,
    parameter int DEPTH = 512
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_we,
    input  logic [clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]        i_wdata,
    input  logic                    i_re,
    input  logic [clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]        o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // NOTE: the array is never reset so it can map onto block RAM; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/tx_lane_fifo.sv
// Width-down-converting packet FIFO: LANES x 9-bit words in, one 9-bit lane out per read.
module tx_lane_fifo
    import tx_lane_pkg::*;
#(
    parameter int LANES = TX_LANES_64,
    parameter int DEPTH = 512
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [LANES*LANE_W-1:0] din,
    input  logic                    wr_en,
    input  logic                    rd_en,
    output logic [LANE_W-1:0]       dout,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_full
);

    localparam int AW = clog2(DEPTH);
    localparam int LW = clog2(LANES);
    localparam int CW = clog2(DEPTH * LANES) + 1;

    localparam logic [CW-1:0] LANES_C   = CW'(LANES);
    localparam logic [CW-1:0] FULL_TH   = CW'((DEPTH - 1) * LANES);
    localparam logic [CW-1:0] AF_TH     = CW'((DEPTH - 2) * LANES);
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    logic [AW-1:0]           r_wptr;
    logic [AW-1:0]           r_rptr;
    logic [LW-1:0]           r_lane;
    logic [LW-1:0]           r_lane_sel;
    logic [CW-1:0]           r_lanes_used;
    logic                    w_wr_acc;
    logic                    w_rd_acc;
    logic [LANES*LANE_W-1:0] w_rdata;

    assign empty       = (r_lanes_used == '0);
    assign full        = (r_lanes_used > FULL_TH);
    assign almost_full = (r_lanes_used > AF_TH);
    assign w_wr_acc    = wr_en & ~full;
    assign w_rd_acc    = rd_en & ~empty;

    // A write can only hit the word being read when every slot is occupied, which full blocks.
    tx_lane_ram #(
        .WIDTH (LANES * LANE_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (reset),
        .i_we    (w_wr_acc),
        .i_waddr (r_wptr),
        .i_wdata (din),
        .i_re    (w_rd_acc),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_lane       <= '0;
            r_lane_sel   <= '0;
            r_lanes_used <= '0;
        end else begin
            if (w_wr_acc) r_wptr <= r_wptr + AW'(1);
            if (w_rd_acc) begin
                r_lane_sel <= r_lane;
                if (r_lane == LAST_LANE) begin
                    r_lane <= '0;
                    r_rptr <= r_rptr + AW'(1);
                end else begin
                    r_lane <= r_lane + LW'(1);
                end
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_lanes_used <= r_lanes_used + LANES_C;
                2'b01:   r_lanes_used <= r_lanes_used - CW'(1);
                2'b11:   r_lanes_used <= r_lanes_used + LANES_C - CW'(1);
                default: ;
            endcase
        end
    end

    // RAM word and lane select both load on the read edge, so dout is register-driven and holds otherwise.
    assign dout = w_rdata[r_lane_sel*LANE_W +: LANE_W];

endmodule

// File: tb/tb_tx_lane_fifo.sv
// Directed self-checking bench for tx_lane_fifo at LANES=8/DEPTH=512 and LANES=4/DEPTH=4.
module tb_tx_lane_fifo;
    import tx_lane_pkg::*;

    localparam int L8 = TX_LANES_64;
    localparam int D8 = 512;
    localparam int L4 = TX_LANES_32;
    localparam int D4 = 4;
    localparam int W8 = L8 * LANE_W;
    localparam int W4 = L4 * LANE_W;

    logic          clk = 1'b0;
    logic          reset;
    logic [W8-1:0] din8;
    logic          wr8, rd8;
    logic [8:0]    dout8;
    logic          empty8, full8, af8;
    logic [W4-1:0] din4;
    logic          wr4, rd4;
    logic [8:0]    dout4;
    logic          empty4, full4, af4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tx_lane_fifo #(.LANES(L8), .DEPTH(D8)) dut8 (
        .clk(clk), .reset(reset), .din(din8), .wr_en(wr8), .rd_en(rd8),
        .dout(dout8), .empty(empty8), .full(full8), .almost_full(af8)
    );

    tx_lane_fifo #(.LANES(L4), .DEPTH(D4)) dut4 (
        .clk(clk), .reset(reset), .din(din4), .wr_en(wr4), .rd_en(rd4),
        .dout(dout4), .empty(empty4), .full(full4), .almost_full(af4)
    );

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] lane8(input int n, input int l);
        logic ctrl;
        ctrl = (l == L8 - 1) ^ n[8];
        return {ctrl, 8'(n * 5 + l * 29)};
    endfunction

    function automatic logic [W8-1:0] word8(input int n);
        logic [W8-1:0] w;
        for (int l = 0; l < L8; l++) w[l*LANE_W +: LANE_W] = lane8(n, l);
        return w;
    endfunction

    function automatic logic [8:0] lane4(input int n, input int l);
        return {1'(l == L4 - 1), 8'(n * 16 + l + 1)};
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        wr8 = 1'b0; rd8 = 1'b0; din8 = '0;
        wr4 = 1'b0; rd4 = 1'b0; din4 = '0;
        repeat (3) step();
        n_checks++;
        if ({empty8, full8, af8, dout8} !== {3'b100, 9'h000}) begin
            n_fail++;
            $display("FAIL reset_state8: got e/f/af/dout=%b%b%b/%h expected 100/000", empty8, full8, af8, dout8);
        end
        n_checks++;
        if ({empty4, full4, af4, dout4} !== {3'b100, 9'h000}) begin
            n_fail++;
            $display("FAIL reset_state4: got e/f/af/dout=%b%b%b/%h expected 100/000", empty4, full4, af4, dout4);
        end
        reset = 1'b1;
        step();
        rd8 = 1'b1; rd4 = 1'b1;
        step();
        rd8 = 1'b0; rd4 = 1'b0;
        n_checks++;
        if ({empty8, dout8} !== {1'b1, 9'h000}) begin
            n_fail++;
            $display("FAIL read_while_empty8: got empty=%b dout=%h expected 1/000", empty8, dout8);
        end
        n_checks++;
        if ({empty4, dout4} !== {1'b1, 9'h000}) begin
            n_fail++;
            $display("FAIL read_while_empty4: got empty=%b dout=%h expected 1/000", empty4, dout4);
        end
    endtask

    task automatic test_single_word();
        logic [8:0] exp;
        for (int l = 0; l < L8; l++) din8[l*LANE_W +: LANE_W] = {1'(l == 7), 8'(16 + l)};
        wr8 = 1'b1;
        step();
        wr8 = 1'b0;
        n_checks++;
        if (empty8 !== 1'b0) begin
            n_fail++;
            $display("FAIL write_to_empty: empty got %b expected 0", empty8);
        end
        rd8 = 1'b1;
        for (int i = 0; i < L8; i++) begin
            step();
            exp = {1'(i == 7), 8'(16 + i)};
            n_checks++;
            if (dout8 !== exp) begin
                n_fail++;
                $display("FAIL single_word_lane%0d: dout got %h expected %h", i, dout8, exp);
            end
        end
        n_checks++;
        if (empty8 !== 1'b1) begin
            n_fail++;
            $display("FAIL single_word_drained: empty got %b expected 1", empty8);
        end
        step();
        rd8 = 1'b0;
        n_checks++;
        if (dout8 !== 9'h117) begin
            n_fail++;
            $display("FAIL ninth_read_holds: dout got %h expected 117", dout8);
        end
    endtask

    task automatic test_lanes4();
        logic [8:0] exp [4];
        exp = '{9'h0DD, 9'h0CC, 9'h0BB, 9'h1AA};
        din4 = {9'h1AA, 9'h0BB, 9'h0CC, 9'h0DD};
        wr4 = 1'b1;
        step();
        wr4 = 1'b0;
        rd4 = 1'b1;
        for (int i = 0; i < L4; i++) begin
            step();
            n_checks++;
            if (dout4 !== exp[i]) begin
                n_fail++;
                $display("FAIL lanes4_pop%0d: dout got %h expected %h", i, dout4, exp[i]);
            end
        end
        rd4 = 1'b0;
        n_checks++;
        if (empty4 !== 1'b1) begin
            n_fail++;
            $display("FAIL lanes4_drained: empty got %b expected 1", empty4);
        end
    endtask

    // Small-depth fill: almost_full at DEPTH-1 words, full at DEPTH words, pointers wrap.
    task automatic test_fill4();
        logic [1:0] exp_flags [4];
        int bad;
        exp_flags = '{2'b00, 2'b00, 2'b10, 2'b11};
        wr4 = 1'b1;
        for (int n = 0; n < D4; n++) begin
            for (int l = 0; l < L4; l++) din4[l*LANE_W +: LANE_W] = lane4(n, l);
            step();
            n_checks++;
            if ({af4, full4} !== exp_flags[n]) begin
                n_fail++;
                $display("FAIL fill4_flags_%0dwords: af/full got %b%b expected %b", n + 1, af4, full4, exp_flags[n]);
            end
        end
        din4 = '1;
        step();
        wr4 = 1'b0;
        rd4 = 1'b1;
        bad = 0;
        for (int k = 0; k < D4 * L4; k++) begin
            step();
            if (dout4 !== lane4(k / L4, k % L4)) bad++;
        end
        rd4 = 1'b0;
        n_checks++;
        if ({bad, empty4} !== {32'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL fill4_readback: bad lanes=%0d empty=%b expected 0 bad and empty=1", bad, empty4);
        end
    endtask

    // Thresholds: almost_full once used > (DEPTH-2)*LANES, full once used > (DEPTH-1)*LANES.
    task automatic test_fill();
        int bad, first_bad;
        logic [8:0] exp;
        wr8 = 1'b1;
        for (int n = 0; n < D8; n++) begin
            din8 = word8(n);
            step();
            if (n == D8 - 3 || n == D8 - 2 || n == D8 - 1) begin
                n_checks++;
                if ({af8, full8} !== {1'(n >= D8 - 2), 1'(n == D8 - 1)}) begin
                    n_fail++;
                    $display("FAIL fill_flags_%0dwords: af/full got %b%b expected %b%b",
                             n + 1, af8, full8, 1'(n >= D8 - 2), 1'(n == D8 - 1));
                end
            end
        end
        din8 = '1;
        step();
        wr8 = 1'b0;
        n_checks++;
        if ({full8, int'(dut8.r_lanes_used)} !== {1'b1, D8 * L8}) begin
            n_fail++;
            $display("FAIL write_when_full_dropped: full=%b lanes_used=%0d expected 1/%0d",
                     full8, dut8.r_lanes_used, D8 * L8);
        end
        rd8 = 1'b1;
        bad = 0;
        first_bad = -1;
        for (int k = 0; k < D8 * L8; k++) begin
            step();
            exp = lane8(k / L8, k % L8);
            if (dout8 !== exp) begin
                if (bad == 0) first_bad = k;
                bad++;
            end
            if (k == L8 - 2 || k == L8 - 1) begin
                n_checks++;
                if ({af8, full8} !== {1'b1, 1'(k == L8 - 2)}) begin
                    n_fail++;
                    $display("FAIL slot_free_after_%0dreads: af/full got %b%b expected 1%b",
                             k + 1, af8, full8, 1'(k == L8 - 2));
                end
            end
        end
        rd8 = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL fill_readback: %0d bad lanes (first at %0d) expected 0", bad, first_bad);
        end
        n_checks++;
        if (empty8 !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_drained: empty got %b expected 1", empty8);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] q [$];
        logic [8:0] exp_dout;
        int used, n, bad_data, bad_used, bad_flags, both_cycles;
        logic wacc, racc;
        used = 0;
        n = 1000;
        exp_dout = lane8(D8 - 1, L8 - 1);
        bad_data = 0; bad_used = 0; bad_flags = 0; both_cycles = 0;
        wr8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din8 = word8(n);
            step();
            for (int l = 0; l < L8; l++) q.push_back(lane8(n, l));
            used += L8;
            n++;
        end
        din8 = word8(n);
        rd8 = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            wacc = (used <= (D8 - 1) * L8);
            racc = (used > 0);
            step();
            if (racc) exp_dout = q.pop_front();
            if (wacc) begin
                for (int l = 0; l < L8; l++) q.push_back(lane8(n, l));
                n++;
                din8 = word8(n);
            end
            used += (wacc ? L8 : 0) - (racc ? 1 : 0);
            if (wacc && racc) both_cycles++;
            if (dout8 !== exp_dout) bad_data++;
            if (int'(dut8.r_lanes_used) != used) bad_used++;
            if ({empty8, full8, af8} !== {1'(used == 0), 1'(used > (D8 - 1) * L8), 1'(used > (D8 - 2) * L8)})
                bad_flags++;
        end
        wr8 = 1'b0;
        rd8 = 1'b0;
        n_checks++;
        if (bad_data != 0) begin
            n_fail++;
            $display("FAIL b2b_lane_order: %0d cycles with wrong dout, expected 0", bad_data);
        end
        n_checks++;
        if (bad_used != 0) begin
            n_fail++;
            $display("FAIL b2b_lanes_used: %0d cycles off model (%0d with both ports), expected 0", bad_used, both_cycles);
        end
        n_checks++;
        if (bad_flags != 0) begin
            n_fail++;
            $display("FAIL b2b_flags: %0d cycles with wrong flags, expected 0", bad_flags);
        end
    endtask

    task automatic test_async_reset();
        int bad;
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        wr8 = 1'b1;
        for (int n = 0; n < 5; n++) begin
            din8 = word8(2000 + n);
            step();
        end
        wr8 = 1'b0;
        rd8 = 1'b1;
        repeat (2) step();
        rd8 = 1'b0;
        n_checks++;
        if (dout8 !== lane8(2000, 1)) begin
            n_fail++;
            $display("FAIL pre_reset_dout: got %h expected %h", dout8, lane8(2000, 1));
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({empty8, full8, af8, dout8} !== {3'b100, 9'h000}) begin
            n_fail++;
            $display("FAIL async_reset_midburst: got e/f/af/dout=%b%b%b/%h expected 100/000", empty8, full8, af8, dout8);
        end
        step();
        reset = 1'b1;
        step();
        din8 = word8(3000);
        wr8 = 1'b1;
        step();
        wr8 = 1'b0;
        rd8 = 1'b1;
        bad = 0;
        for (int l = 0; l < L8; l++) begin
            step();
            if (dout8 !== lane8(3000, l)) bad++;
        end
        rd8 = 1'b0;
        n_checks++;
        if ({bad, empty8} !== {32'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL post_reset_readback: bad lanes=%0d empty=%b expected 0 bad and empty=1", bad, empty8);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_word();
        test_lanes4();
        test_fill4();
        test_fill();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
